uart_alu_interface: RTL

//  Sequencer between the UART receiver, the ALU and the UART transmitter. Collects three

---
 rtl/uart_alu_if.sv | 28 ++
 rtl/uart_alu_interface.sv | 110 +++++++++++
 2 files changed

// File: rtl/uart_alu_if.sv
// Bundle of signals between the UART/ALU sequencer and the receiver, ALU and transmitter.
// The master modport is the sequencer's own view of the bundle.
interface uart_alu_if #(
   parameter int NBIT_DATA = 8,
   parameter int NBIT_OP   = 6
);
   logic                 rx_done_tick;
   logic [NBIT_DATA-1:0] rx_data;
   logic [NBIT_DATA-1:0] alu_result;
   logic                 tx_done_tick;
   logic [NBIT_DATA-1:0] alu_a;
   logic [NBIT_DATA-1:0] alu_b;
   logic [NBIT_OP-1:0]   alu_op;
   logic                 tx_start;
   logic [NBIT_DATA-1:0] tx_data;
   logic                 busy;
   logic                 timeout_err;

   modport master (
      input  rx_done_tick, rx_data, alu_result, tx_done_tick,
      output alu_a, alu_b, alu_op, tx_start, tx_data, busy, timeout_err
   );

   modport slave (
      output rx_done_tick, rx_data, alu_result, tx_done_tick,
      input  alu_a, alu_b, alu_op, tx_start, tx_data, busy, timeout_err
   );
endinterface

// File: rtl/uart_alu_interface.sv
// Collects operand A, operand B and opcode from the UART receiver, lets the ALU settle,
// then launches one transmit of the result. An inter-byte timeout aborts a stalled frame.
module uart_alu_interface #(
   parameter int NBIT_DATA   = 8,
   parameter int NBIT_OP     = 6,
   parameter int TIMEOUT_CYC = 1000000,
   parameter int LEN_TIMEOUT = 20
) (
   input  logic      clk,
   input  logic      reset,
   uart_alu_if.master bus
);

   typedef enum logic [2:0] {
      IDLE_A  = 3'd0,
      GET_B   = 3'd1,
      GET_OP  = 3'd2,
      EXEC    = 3'd3,
      WAIT_TX = 3'd4
   } state_t;

   state_t                 state;
   logic                   rx_prev;
   logic                   tx_prev;
   logic [LEN_TIMEOUT-1:0] to_cnt;
   logic                   rx_evt;
   logic                   tx_evt;
   logic                   expired;

   // Rising-edge events: a level held high by the receiver/transmitter counts once.
   assign rx_evt  = bus.rx_done_tick & ~rx_prev;
   assign tx_evt  = bus.tx_done_tick & ~tx_prev;
   assign expired = (TIMEOUT_CYC != 0) && (to_cnt == LEN_TIMEOUT'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE_A;
         rx_prev         <= 1'b0;
         tx_prev         <= 1'b0;
         to_cnt          <= '0;
         bus.alu_a       <= '0;
         bus.alu_b       <= '0;
         bus.alu_op      <= '0;
         bus.tx_data     <= '0;
         bus.tx_start    <= 1'b0;
         bus.busy        <= 1'b0;
         bus.timeout_err <= 1'b0;
      end else begin
         rx_prev         <= bus.rx_done_tick;
         tx_prev         <= bus.tx_done_tick;
         bus.tx_start    <= 1'b0;
         bus.timeout_err <= 1'b0;
         case (state)
            IDLE_A: begin
               if (rx_evt) begin
                  bus.alu_a <= bus.rx_data;
                  to_cnt    <= '0;
                  state     <= GET_B;
                  bus.busy  <= 1'b1;
               end
            end
            GET_B: begin
               // A byte arriving on the expiry cycle takes priority over the abort.
               if (rx_evt) begin
                  bus.alu_b <= bus.rx_data;
                  to_cnt    <= '0;
                  state     <= GET_OP;
               end else if (expired) begin
                  to_cnt          <= '0;
                  state           <= IDLE_A;
                  bus.busy        <= 1'b0;
                  bus.timeout_err <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + LEN_TIMEOUT'(1);
               end
            end
            GET_OP: begin
               if (rx_evt) begin
                  bus.alu_op <= bus.rx_data[NBIT_OP-1:0];
                  state      <= EXEC;
               end else if (expired) begin
                  to_cnt          <= '0;
                  state           <= IDLE_A;
                  bus.busy        <= 1'b0;
                  bus.timeout_err <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + LEN_TIMEOUT'(1);
               end
            end
            EXEC: begin
               // The ALU has had one full cycle on the new operands; latch its result.
               bus.tx_data  <= bus.alu_result;
               bus.tx_start <= 1'b1;
               state        <= WAIT_TX;
            end
            WAIT_TX: begin
               if (tx_evt) begin
                  state    <= IDLE_A;
                  bus.busy <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE_A;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
